// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive demultiplexer.
package tdm_pkg;

  localparam int unsigned TDM_WIDTH  = 8;
  localparam int unsigned TDM_SLOT_W = $clog2(TDM_WIDTH);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } tdm_state_e;

  typedef logic [TDM_SLOT_W-1:0] tdm_slot_t;

endpackage

// File: rtl/tdm_out_reg.sv
// One-entry valid/ready holding register for assembled words.
module tdm_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             blocked
);

  // A load can only be taken when the entry is empty or draining this cycle.
  assign blocked = dout_valid && !dout_ready;

  // Hold register: load new word if room, otherwise drain on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load && !blocked) begin
      dout       <= load_word;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// TDM serial-to-parallel receiver: slot FSM, frame assembly, output register.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = TDM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             sync_err,
  output logic             locked
);

  localparam int unsigned SLOT_W = $clog2(WIDTH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WIDTH - 1);

  tdm_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WIDTH-1:0]  asm_q, asm_d;
  logic              sync_err_d;
  logic              overrun_d;
  logic              load;
  logic [WIDTH-1:0]  load_word;
  logic              blocked;

  // Slot FSM and assembly register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      asm_q    <= '0;
      sync_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      asm_q    <= asm_d;
      sync_err <= sync_err_d;
      overrun  <= overrun_d;
    end
  end

  // Next-state: hunt for sync, collect slots, emit completed frames.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    asm_d      = asm_q;
    sync_err_d = 1'b0;
    load       = 1'b0;
    load_word  = '0;
    if (sin_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sin_sync) begin
            asm_d    = '0;
            asm_d[0] = sin_data;
            slot_d   = SLOT_W'(1);
            state_d  = COLLECT;
          end
        end
        COLLECT: begin
          if (sin_sync && (slot_q != '0)) begin
            // Misplaced sync restarts the frame with this bit as slot 0.
            sync_err_d = 1'b1;
            asm_d      = '0;
            asm_d[0]   = sin_data;
            slot_d     = SLOT_W'(1);
          end else begin
            asm_d[slot_q] = sin_data;
            slot_d        = slot_q + 1'b1;
            if (slot_q == LAST_SLOT) begin
              load      = 1'b1;
              load_word = {sin_data, asm_q[WIDTH-2:0]};
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Sticky overrun: a dropped frame outranks a simultaneous clear.
  always_comb begin
    overrun_d = overrun;
    if (load && blocked)
      overrun_d = 1'b1;
    else if (clr_ovr)
      overrun_d = 1'b0;
  end

  assign locked = (state_q == COLLECT);

  tdm_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_word  (load_word),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .blocked    (blocked)
  );

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: directed scenarios plus randomized run.
module tb_tdm_demux8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sin_data = 1'b0;
  logic         sin_sync = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         overrun;
  logic         clr_ovr = 1'b0;
  logic         sync_err;
  logic         locked;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: frame position as an integer, one-entry output slot.
  bit           m_locked;
  int           m_pos;
  logic [W-1:0] m_word;
  logic [W-1:0] m_dout;
  bit           m_dv;
  bit           m_ovr;
  bit           m_serr;

  tdm_demux8 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin_valid  (sin_valid),
    .sin_data   (sin_data),
    .sin_sync   (sin_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_locked = 0; m_pos = 0; m_word = '0; m_dout = '0;
    m_dv = 0; m_ovr = 0; m_serr = 0;
  endtask

  // One clock: advance the model with the inputs present at the edge.
  task automatic step();
    bit           done;
    bit           full;
    bit           serr;
    logic [W-1:0] cw;
    @(posedge clk);
    full = m_dv && !dout_ready;
    done = 0; serr = 0; cw = '0;
    if (sin_valid) begin
      if (!m_locked) begin
        if (sin_sync) begin
          m_locked = 1; m_word = W'(sin_data); m_pos = 1;
        end
      end else if (sin_sync && m_pos != 0) begin
        serr = 1; m_word = W'(sin_data); m_pos = 1;
      end else begin
        m_word[m_pos] = sin_data;
        if (m_pos == W - 1) begin
          done = 1; cw = m_word;
        end
        m_pos = (m_pos + 1) % W;
      end
    end
    if (done && !full) begin
      m_dout = cw; m_dv = 1;
    end else if (m_dv && dout_ready) begin
      m_dv = 0;
    end
    if (done && full) m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
    m_serr = serr;
    cyc++;
    #1;
  endtask

  task automatic stroke(input logic d, input logic s);
    sin_valid = 1'b1; sin_data = d; sin_sync = s;
    step();
    sin_valid = 1'b0; sin_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) stroke(w[i], i == 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b exp=0", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_serr got=%b exp=0", sync_err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lock_frame();
    logic [W-1:0] w;
    w = 8'hA5;
    dout_ready = 1'b1;
    for (int i = 0; i < W; i++) begin
      stroke(w[i], i == 0);
      if (i < W - 1) begin
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL lock_early_dv slot=%0d got=%b exp=0", i, dout_valid); end
      end
    end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL lock_dv got=%b exp=1", dout_valid); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL lock_dout got=%h exp=a5", dout); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked got=%b exp=1", locked); end
    idle(1);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL lock_drain got=%b exp=0", dout_valid); end
  endtask

  task automatic test_garbage_gaps();
    logic [W-1:0] w;
    int serr_seen;
    w = 8'h3C;
    serr_seen = 0;
    apply_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) stroke(1'($urandom), 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL garbage_locked got=%b exp=0", locked); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL garbage_dv got=%b exp=0", dout_valid); end
    for (int i = 0; i < W; i++) begin
      stroke(w[i], i == 0);
      if (sync_err) serr_seen++;
      if (i == 3) begin
        idle(2);
        if (sync_err) serr_seen++;
      end
    end
    checks++; if (dout !== 8'h3C || dout_valid !== 1'b1) begin errors++; $display("FAIL gaps_dout got=%h/%b exp=3c/1", dout, dout_valid); end
    checks++; if (serr_seen !== 0) begin errors++; $display("FAIL gaps_serr got=%0d exp=0", serr_seen); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] fr [3];
    logic [W-1:0] got [$];
    int           at [$];
    fr[0] = 8'h01; fr[1] = 8'h80; fr[2] = 8'hFF;
    dout_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < W; i++) begin
        stroke(fr[f][i], i == 0);
        if (dout_valid) begin got.push_back(dout); at.push_back(cyc); end
      end
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL b2b_count got=%0d exp=3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (got[k] !== fr[k]) begin errors++; $display("FAIL b2b_word k=%0d got=%h exp=%h", k, got[k], fr[k]); end
      end
      checks++; if (at[1] - at[0] != W || at[2] - at[1] != W) begin errors++; $display("FAIL b2b_spacing got=%0d,%0d exp=8,8", at[1] - at[0], at[2] - at[1]); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr got=%b exp=0", overrun); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w;
    idle(1);
    dout_ready = 1'b0;
    send_frame(8'h55);
    checks++; if (dout !== 8'h55 || dout_valid !== 1'b1) begin errors++; $display("FAIL bp_first got=%h/%b exp=55/1", dout, dout_valid); end
    send_frame(8'hAA);
    checks++; if (dout !== 8'h55) begin errors++; $display("FAIL bp_hold got=%h exp=55", dout); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_ovr got=%b exp=1", overrun); end
    dout_ready = 1'b1;
    idle(1);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", dout_valid); end
    clr_ovr = 1'b1; idle(1); clr_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_clr got=%b exp=0", overrun); end
    dout_ready = 1'b0;
    send_frame(8'h55);
    w = 8'hAA;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) clr_ovr = 1'b1;
      stroke(w[i], i == 0);
      clr_ovr = 1'b0;
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_set_wins got=%b exp=1", overrun); end
    dout_ready = 1'b1; clr_ovr = 1'b1; idle(1); clr_ovr = 1'b0;
    checks++; if (overrun !== 1'b0 || dout_valid !== 1'b0) begin errors++; $display("FAIL bp_final got=%b/%b exp=0/0", overrun, dout_valid); end
  endtask

  task automatic test_resync();
    logic [W-1:0] w;
    int pulses;
    int early;
    w = 8'hC3;
    pulses = 0; early = 0;
    dout_ready = 1'b1;
    stroke(1'b1, 1'b1);
    for (int i = 1; i < 5; i++) stroke(1'($urandom), 1'b0);
    stroke(w[0], 1'b1);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL resync_pulse got=%b exp=1", sync_err); end
    for (int i = 1; i < W; i++) begin
      stroke(w[i], 1'b0);
      if (sync_err) pulses++;
      if (dout_valid && i < W - 1) early++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL resync_extra got=%0d exp=0", pulses); end
    checks++; if (early !== 0) begin errors++; $display("FAIL resync_partial got=%0d exp=0", early); end
    checks++; if (dout !== 8'hC3 || dout_valid !== 1'b1) begin errors++; $display("FAIL resync_dout got=%h/%b exp=c3/1", dout, dout_valid); end
  endtask

  task automatic test_reset_midframe();
    dout_ready = 1'b0;
    stroke(1'b1, 1'b1);
    for (int i = 1; i < 5; i++) stroke(1'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out got=%h/%b exp=00/0", dout, dout_valid); end
    checks++; if (locked !== 1'b0 || overrun !== 1'b0 || sync_err !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got=%b%b%b exp=000", locked, overrun, sync_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) stroke(1'b1, 1'b0);
    checks++; if (locked !== 1'b0 || dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_hunt got=%b/%b exp=0/0", locked, dout_valid); end
    send_frame(8'h96);
    checks++; if (dout !== 8'h96 || dout_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_frame got=%h/%b exp=96/1", dout, dout_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      sin_valid  = ($urandom_range(0, 3) != 0);
      sin_data   = 1'($urandom);
      sin_sync   = (m_pos == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 23) == 0);
      dout_ready = ($urandom_range(0, 2) != 0);
      clr_ovr    = ($urandom_range(0, 9) == 0);
      step();
      checks++; if (dout !== m_dout) begin errors++; $display("FAIL rnd_dout n=%0d got=%h exp=%h", n, dout, m_dout); end
      checks++; if (dout_valid !== m_dv) begin errors++; $display("FAIL rnd_dv n=%0d got=%b exp=%b", n, dout_valid, m_dv); end
      checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr n=%0d got=%b exp=%b", n, overrun, m_ovr); end
      checks++; if (sync_err !== m_serr) begin errors++; $display("FAIL rnd_serr n=%0d got=%b exp=%b", n, sync_err, m_serr); end
      checks++; if (locked !== m_locked) begin errors++; $display("FAIL rnd_locked n=%0d got=%b exp=%b", n, locked, m_locked); end
    end
    sin_valid = 1'b0; sin_sync = 1'b0; clr_ovr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_frame();
    test_garbage_gaps();
    test_back_to_back();
    test_backpressure();
    test_resync();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive-side counterpart of the 8:1 select mux: takes a time-division-multiplexed serial stream, one bit per slot, eight slots per frame.
- Rebuilds each frame as a parallel word: slot k lands in dout[k], mirroring sel==k -> D[k] on the transmit side.
- Sits between the serial link and the parallel datapath.
- Delivers words through a valid/ready output register with overrun and sync-error reporting.

Parameters:
- WIDTH, 8, slots per frame and output word width. Must be a power of 2, >= 2.
- SLOT_W, $clog2(WIDTH), slot counter width (3 at default). Derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- sin_valid  in  1  slot strobe; sin_data/sin_sync sampled only when high
- sin_data  in  1  serial bit for the current slot
- sin_sync  in  1  marks the current bit as slot 0
- dout  out  WIDTH  assembled word; slot k -> dout[k]
- dout_valid  out  1  dout holds an unconsumed word
- dout_ready  in  1  consumer accepts; transfer when dout_valid && dout_ready
- overrun  out  1  sticky; a completed frame was dropped
- clr_ovr  in  1  clears overrun
- sync_err  out  1  one-cycle pulse; sync seen at a nonzero slot
- locked  out  1  high in COLLECT state

Behaviour:
- Reset (async assert, sync release): state HUNT, slot=0, assembly reg=0, dout=0, dout_valid=0, overrun=0, sync_err=0, locked=0.
- sin_valid low: no state, slot or assembly change. Output handshake still operates.
- HUNT:
  - Stroke without sync is ignored.
  - sin_valid && sin_sync: asm[0]=sin_data, slot=1, go to COLLECT.
- COLLECT, on each sin_valid:
  - sin_sync && slot!=0: pulse sync_err next cycle. Discard the partial frame (clear asm). Take this bit as slot 0: asm[0]=sin_data, slot=1. Stay in COLLECT.
  - Otherwise: asm[slot]=sin_data, slot=slot+1 (wraps WIDTH-1 -> 0).
  - Slot 0 without sync is legal in COLLECT (free-running frames).
- Frame completion: a stroke at slot WIDTH-1. The completed word is {sin_data, asm[WIDTH-2:0]}.
  - If dout_valid==0, or dout_ready==1 in the same cycle: load dout, dout_valid=1 after that edge. Latency is one cycle from the last-bit edge.
  - Else: keep the old dout, drop the new word, set overrun.
- Output handshake: transfer when dout_valid && dout_ready. With no new word loading, dout_valid clears on the next edge. dout stays stable while dout_valid && !dout_ready.
- overrun stays set until clr_ovr. If clr_ovr and a new overrun event occur in the same cycle, the set wins.
- Back-to-back frames at full rate (sin_valid every cycle) with dout_ready tied high: one word every WIDTH cycles, no loss.
- No combinational path from sin_* to dout*. dout_ready reaches only the next-state logic.

Decomposition:
- Package tdm_pkg holds:
  - state enum {HUNT, COLLECT}
  - TDM_WIDTH=8 default constant
  - slot type logic [SLOT_W-1:0]
- One sub-module, tdm_out_reg: a one-entry valid/ready holding register. It takes a load strobe and load word, exposes dout/dout_valid/dout_ready, and returns a "full and not draining" signal used to generate overrun.
- Slot FSM and assembly register live in tdm_demux8.

Test Plan:
- Lock and one frame: sync on slot 0, then bits 1,0,1,0,0,1,0,1 with dout_ready=1 -> dout=8'hA5 and dout_valid high exactly one cycle after the 8th strobe; locked=1.
- Pre-sync garbage and gaps: 5 strokes without sync, then frame 8'h3C with sin_valid low for 2 cycles between slots 3 and 4 -> garbage ignored; dout=8'h3C; no sync_err.
- Back-to-back: frames 8'h01, 8'h80, 8'hFF continuous, dout_ready=1 -> three words, 8 cycles apart, correct order, overrun=0.
- Backpressure: dout_ready=0 over two frames 8'h55, 8'hAA -> dout holds 8'h55, overrun=1. Then dout_ready=1 -> 8'h55 consumed, dout_valid=0. clr_ovr -> overrun=0. Repeat with clr_ovr asserted on the overrun cycle -> overrun stays 1.
- Resync: sync at slot 5 mid-frame, then 7 more bits forming 8'hC3 -> sync_err pulses once, partial discarded, dout=8'hC3.
- Reset mid-frame: rst_n low after slot 4 -> all outputs 0, state HUNT. After release, strokes without sync are ignored; a new synced frame 8'h96 yields dout=8'h96.
